// File: rtl/noc_addr_pkg.sv
// ---------------------------------------------------------------------------
// noc_addr_pkg
// Shared definitions for the NoC master/slave return-path blocks.
//   ADDRESS_WIDTH_DEFAULT : default width of a NoC router address
//   cnt_width(n)          : bits needed to hold a count in the range 0..n
// ---------------------------------------------------------------------------
package noc_addr_pkg;

  localparam int ADDRESS_WIDTH_DEFAULT = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reply_matcher_if.sv
// ---------------------------------------------------------------------------
// reply_matcher_if
// Request/reply signal bundle of the reply matcher.
//   master : request issue (i_dst_in/i_valid_in), reply arrival
//            (r_src_in/r_valid_in) and timeout clear; observes status
//   slave  : the matcher; drives ready, result pulses, expected address,
//            timeout flag and outstanding count
// ---------------------------------------------------------------------------
interface reply_matcher_if
  import noc_addr_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = ADDRESS_WIDTH_DEFAULT,
  parameter int MAX_OUTSTANDING = 12
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);

  logic [ADDRESS_WIDTH-1:0] i_dst_in;
  logic                     i_valid_in;
  logic                     i_ready_out;
  logic [ADDRESS_WIDTH-1:0] r_src_in;
  logic                     r_valid_in;
  logic                     o_match_out;
  logic                     o_error_out;
  logic                     o_spurious_out;
  logic [ADDRESS_WIDTH-1:0] o_expected_out;
  logic                     o_timeout_out;
  logic                     i_clear_in;
  logic [CW-1:0]            o_outstanding_out;

  modport master (
    output i_dst_in, i_valid_in, r_src_in, r_valid_in, i_clear_in,
    input  i_ready_out, o_match_out, o_error_out, o_spurious_out,
           o_expected_out, o_timeout_out, o_outstanding_out
  );

  modport slave (
    input  i_dst_in, i_valid_in, r_src_in, r_valid_in, i_clear_in,
    output i_ready_out, o_match_out, o_error_out, o_spurious_out,
           o_expected_out, o_timeout_out, o_outstanding_out
  );

endinterface

// File: rtl/reply_matcher_fifo.sv
// ---------------------------------------------------------------------------
// fifo_rm
// Count-based synchronous FIFO with binary pointers that wrap at DEPTH, so
// DEPTH need not be a power of two. Head is visible combinationally.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count)
//   push_i     : write wdata_i at the tail (caller guarantees not full)
//   pop_i      : drop the head entry (caller guarantees not empty)
//   wdata_i    : data to write
//   head_o     : current head entry
//   count_o    : number of stored entries
// ---------------------------------------------------------------------------
module fifo_rm
  import noc_addr_pkg::*;
#(
  parameter int WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int DEPTH = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [WIDTH-1:0]            wdata_i,
  output logic [WIDTH-1:0]            head_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers advance modulo DEPTH; fullness is tracked by count alone.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) begin
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    end
    if (pop_i) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem[wptr_q] <= wdata_i;
    end
  end

  assign head_o  = mem[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/reply_matcher.sv
// ---------------------------------------------------------------------------
// reply_matcher
// Master-side checker: records the destination of every issued request in an
// in-order FIFO and compares each arriving reply source against the head.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : reply_matcher_if.slave -- request issue with ready back-pressure,
//          reply input, match/error/spurious pulses, captured expected
//          address, sticky timeout flag with clear, outstanding count
// ---------------------------------------------------------------------------
module reply_matcher
  import noc_addr_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = ADDRESS_WIDTH_DEFAULT,
  parameter int MAX_OUTSTANDING = 12,
  parameter int TIMEOUT         = 255
) (
  input  logic           clk,
  input  logic           rst,
  reply_matcher_if.slave bus
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam int TW = cnt_width(TIMEOUT);

  logic [CW-1:0]            count;
  logic [ADDRESS_WIDTH-1:0] head;
  logic                     ready;
  logic                     push;
  logic                     pop;
  logic                     hasOut;

  logic                     match_q, match_d;
  logic                     error_q, error_d;
  logic                     spurious_q, spurious_d;
  logic [ADDRESS_WIDTH-1:0] expected_q, expected_d;
  logic                     timeout_q, timeout_d;
  logic [TW-1:0]            tcnt_q, tcnt_d;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never makes room for a push.
  assign ready  = (count != CW'(MAX_OUTSTANDING));
  assign hasOut = (count != '0);
  assign push   = bus.i_valid_in & ready;
  assign pop    = bus.r_valid_in & hasOut;

  fifo_rm #(
    .WIDTH (ADDRESS_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.i_dst_in),
    .head_o  (head),
    .count_o (count)
  );

  // A reply with nothing outstanding is spurious even if a push lands in the
  // same cycle; otherwise the head is always popped to keep ordering intact.
  // The timeout counter restarts on every pop and idles at zero when empty.
  // A clear coinciding with a saturated counter also rewinds the counter so
  // the flag does not re-arm on the very next cycle.
  always_comb begin
    match_d    = pop & (head == bus.r_src_in);
    error_d    = pop & (head != bus.r_src_in);
    spurious_d = bus.r_valid_in & ~hasOut;
    expected_d = pop ? head : expected_q;

    tcnt_d = tcnt_q;
    if (!hasOut || pop) begin
      tcnt_d = '0;
    end else if (tcnt_q != TW'(TIMEOUT)) begin
      tcnt_d = tcnt_q + TW'(1);
    end

    timeout_d = timeout_q | (tcnt_q == TW'(TIMEOUT));
    if (bus.i_clear_in) begin
      timeout_d = 1'b0;
      if (tcnt_q == TW'(TIMEOUT)) begin
        tcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q    <= 1'b0;
      error_q    <= 1'b0;
      spurious_q <= 1'b0;
      expected_q <= '0;
      timeout_q  <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      match_q    <= match_d;
      error_q    <= error_d;
      spurious_q <= spurious_d;
      expected_q <= expected_d;
      timeout_q  <= timeout_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign bus.i_ready_out       = ready;
  assign bus.o_match_out       = match_q;
  assign bus.o_error_out       = error_q;
  assign bus.o_spurious_out    = spurious_q;
  assign bus.o_expected_out    = expected_q;
  assign bus.o_timeout_out     = timeout_q;
  assign bus.o_outstanding_out = count;

endmodule

// File: doc/reply_matcher.md
# reply_matcher

Master-side companion to the slave-side return-destination queue. Every request the master injects into the NoC records its destination router address in an in-order expectation FIFO. Each reply arriving from the NoC is checked against the head of that FIFO. The block also limits outstanding requests (back-pressure), flags mismatched, spurious and overdue replies, and exposes the outstanding count.

## Interface
- ADDRESS_WIDTH, 4, width of NoC router addresses.
- MAX_OUTSTANDING, 12, maximum in-flight requests; depth of the expectation FIFO (≥2).
- TIMEOUT, 255, cycles without a reply while requests are outstanding before a timeout is flagged (≥1).

- clk  in  1  single clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_dst_in  in  ADDRESS_WIDTH  destination of the request being issued.
- i_valid_in  in  1  request issued this cycle.
- i_ready_out  out  1  request may be issued; combinational from the outstanding count.
- r_src_in  in  ADDRESS_WIDTH  source router of the arriving reply.
- r_valid_in  in  1  reply arrives this cycle; always consumed, no back-pressure.
- o_match_out  out  1  one-cycle pulse: reply matched the FIFO head.
- o_error_out  out  1  one-cycle pulse: reply source differed from the FIFO head.
- o_spurious_out  out  1  one-cycle pulse: reply arrived with nothing outstanding.
- o_expected_out  out  ADDRESS_WIDTH  FIFO head captured when the reply was checked; held until the next reply.
- o_timeout_out  out  1  sticky timeout flag.
- i_clear_in  in  1  synchronous clear of o_timeout_out.
- o_outstanding_out  out  $clog2(MAX_OUTSTANDING+1)  current number of in-flight requests.

## Operation
- **Push.** A push occurs when i_valid_in & i_ready_out: i_dst_in is written at the tail.
  - i_ready_out = (count != MAX_OUTSTANDING).
  - A reply popping in the same cycle does not free a slot; the FIFO cannot overflow.
  - i_valid_in while i_ready_out=0 is dropped. No flags are raised for it, and the count is unchanged.
- **Reply with count>0.** The head is popped unconditionally, keeping the FIFO in order.
  - If the head equals r_src_in, o_match_out pulses.
  - Otherwise o_error_out pulses.
  - o_expected_out captures the head in both cases.
- **Reply with count=0.** o_spurious_out pulses, nothing is popped, and o_expected_out is unchanged.
  - A push in the same cycle is not bypassed: the reply is still spurious and the pushed entry remains.
- **Count update.** count = count + push − pop. Simultaneous push and pop leaves the count unchanged.
- **FIFO pointers.** Binary read/write pointers modulo MAX_OUTSTANDING, wrapping from MAX_OUTSTANDING−1 to 0. Full/empty is derived from count only; MAX_OUTSTANDING need not be a power of two.
- **Timeout counter.**
  - Cleared to 0 when count=0 or on any pop.
  - Otherwise increments by 1 and saturates at TIMEOUT.
  - o_timeout_out sets the cycle after the counter reaches TIMEOUT.
  - o_timeout_out stays set until i_clear_in=1 or reset.
  - If i_clear_in=1 in the same cycle as a set, the clear wins and the counter is zeroed.

## Timing
- Flag outputs (o_match_out, o_error_out, o_spurious_out) and o_expected_out are registered, one cycle after r_valid_in.
  - Exactly one of the three flags pulses per reply.
  - Back-to-back replies give back-to-back pulses.
- o_outstanding_out and i_ready_out reflect the count register; they update the cycle after a push or pop.
- Reset (rst=0, any time, asynchronous):
  - count, pointers and the timeout counter go to 0.
  - All pulse outputs, o_timeout_out and o_expected_out go to 0.
  - i_ready_out goes to 1.
  - FIFO contents are not reset; all in-flight expectations are lost.
  - Replies after reset are spurious.
- Reset release is synchronised by the integrator; the block does not act on the first edge after deassertion differently.

## Structure
- A shared package (noc_addr_pkg) holds the address width default and the count-width function $clog2(N+1); the slave-side return queue uses the same package.
- Sub-module fifo_rm: the binary-pointer, count-based synchronous FIFO.
  - Head visible combinationally.
  - Asynchronous active-low reset of pointers and count.
  - Width ADDRESS_WIDTH, depth MAX_OUTSTANDING.
- The top level contains the push/pop qualification, the compare and flag registers, and the timeout counter.

## Test plan
- **In-order matches.** Reset, issue destinations 3, 7, 9, then replies from 3, 7, 9 -> three o_match_out pulses, count ends at 0, no other flags.
- **Back-pressure.** Issue 12 requests with MAX_OUTSTANDING=12 -> i_ready_out=0 and count=12. A 13th i_valid_in is dropped. One reply brings i_ready_out back to 1 the next cycle.
- **Mismatch.** Outstanding {5}, reply from 6 -> o_error_out pulse, o_expected_out=5, count=0.
- **Spurious with simultaneous push.** Reply when count=0, with a push of 4 in the same cycle -> o_spurious_out pulse, count=1. A following reply from 4 matches.
- **Timeout.** TIMEOUT=10, one request, no reply -> o_timeout_out=1 about 11 cycles later. A reply does not clear it; i_clear_in does.
- **Wrap and mid-operation reset.**
  - With MAX_OUTSTANDING=12, interleave 30 pushes and pops so the pointers wrap -> all match.
  - Assert rst with count=5 -> all outputs 0 and i_ready_out=1 immediately; subsequent replies are spurious.
